wb_host_arbiter: RTL and testbench

Two-master Wishbone arbiter placed inside the user project top, between the Caravel management Wishbone slave port and the internal user-core bus. It shares that single bus between the management SoC (master 0) and a logic-analyzer-driven debug master (master 1). The arbiter uses round-robin arbitration and locks ownership for a whole `cyc` cycle. A watchdog terminates stalled transfers with an error and raises a user IRQ.

---
 rtl/wb_host_arbiter.sv | 95 +++++++++
 tb/tb_wb_host_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_host_arbiter.sv
// wb_host_arbiter: round-robin two-master Wishbone arbiter with whole-cycle ownership lock
// and a stall watchdog that error-terminates hung beats and pulses an IRQ.
module wb_host_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [DW-1:0]   m1_dat_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_dat_i,
    output logic [1:0]      grant_o,
    output logic            irq_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;

    state_t        state;
    logic          last_grant;
    logic [CW-1:0] tcnt;
    logic          req0, req1, own, pick1, cyc, stb, stall, timeout;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign own     = state != IDLE;
    assign pick1   = state == GNT1;
    assign cyc     = pick1 ? m1_cyc_i : m0_cyc_i;
    assign stb     = pick1 ? m1_stb_i : m0_stb_i;
    assign stall   = own & stb & ~s_ack_i;
    assign timeout = stall & (tcnt == CW'(TIMEOUT));

    // The timeout cycle withdraws cyc/stb so the slave sees the beat abandoned
    assign s_cyc_o = own & cyc & ~timeout;
    assign s_stb_o = own & stb & ~timeout;
    assign s_we_o  = own & (pick1 ? m1_we_i : m0_we_i);
    assign s_sel_o = own ? (pick1 ? m1_sel_i : m0_sel_i) : '0;
    assign s_adr_o = own ? (pick1 ? m1_adr_i : m0_adr_i) : '0;
    assign s_dat_o = own ? (pick1 ? m1_dat_i : m0_dat_i) : '0;

    assign m0_ack_o = (state == GNT0) & s_ack_i;
    assign m1_ack_o = (state == GNT1) & s_ack_i;
    assign m0_err_o = (state == GNT0) & timeout;
    assign m1_err_o = (state == GNT1) & timeout;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = state;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            tcnt       <= '0;
            irq_o      <= 1'b0;
        end else begin
            irq_o <= timeout;
            tcnt  <= (stall & ~timeout) ? tcnt + CW'(1) : '0;
            if (state == IDLE) begin
                if (req0 & (~req1 | last_grant)) begin
                    state      <= GNT0;
                    last_grant <= 1'b0;
                end else if (req1) begin
                    state      <= GNT1;
                    last_grant <= 1'b1;
                end
            end else if (timeout | ~cyc) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_wb_host_arbiter.sv
// tb_wb_host_arbiter: directed plan scenarios plus randomized traffic, checked by a scoreboard
// fed from a timestamp-based reference model of arbitration, lock and watchdog rules.
module tb_wb_host_arbiter;
    localparam int T = 4;

    logic        wb_clk_i = 1'b0, wb_rst_i = 1'b1;
    logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0, m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [3:0]  m0_sel_i = 0, m1_sel_i = 0, s_sel_o;
    logic [31:0] m0_adr_i = 0, m0_dat_i = 0, m1_adr_i = 0, m1_dat_i = 0, s_dat_i = 0;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o, irq_o;
    logic        s_ack_i = 0;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic [1:0]  grant_o;

    wb_host_arbiter #(.AW(32), .DW(32), .TIMEOUT(T)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o), .irq_o(irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Per-cycle bus expectation and timestamped master-visible events
    typedef struct {int n; logic [1:0] g; logic c; logic s; logic [31:0] adr;} cyc_t;
    typedef struct {int n; logic [4:0] v; logic [31:0] dat;} ev_t;  // v = {ack0,ack1,err0,err1,irq}
    cyc_t cq[$];
    ev_t  eq[$];

    int tests = 0, failed = 0;
    int owner = -1, last = 1, since = -1, n = 0;
    logic use_dir = 1'b0;
    logic [31:0] dir_adr = 0, dir_dat = 0, dir_mdat = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drives one cycle of stimulus and predicts the DUT's behaviour in that cycle
    task automatic step(input logic c0, s0, c1, s1, ack, rst);
        cyc_t r;
        ev_t  e;
        int   age;
        logic tmo, stb, cx;
        @(posedge wb_clk_i); #1;
        wb_rst_i = rst; s_ack_i = ack;
        m0_cyc_i = c0; m0_stb_i = s0; m1_cyc_i = c1; m1_stb_i = s1;
        m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
        m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
        m0_adr_i = use_dir ? dir_adr : $urandom;
        m1_adr_i = use_dir ? dir_adr : $urandom;
        m0_dat_i = use_dir ? dir_mdat : $urandom;
        m1_dat_i = $urandom;
        s_dat_i  = use_dir ? dir_dat : $urandom;
        r.n = n;
        if (owner < 0) begin
            r.g = 2'b00; r.c = 1'b0; r.s = 1'b0; r.adr = 32'h0;
            cq.push_back(r);
            since = -1;
            if (c0 && s0 && (!(c1 && s1) || last == 1)) owner = 0;
            else if (c1 && s1) owner = 1;
            if (owner >= 0) last = owner;
        end else begin
            stb = (owner == 1) ? s1 : s0;
            cx  = (owner == 1) ? c1 : c0;
            age = (since < 0) ? 0 : n - since;
            tmo = stb && !ack && age == T;
            r.g = (owner == 1) ? 2'b10 : 2'b01;
            r.c = cx && !tmo; r.s = stb && !tmo;
            r.adr = (owner == 1) ? m1_adr_i : m0_adr_i;
            cq.push_back(r);
            if (ack) begin
                e.n = n; e.v = (owner == 1) ? 5'b01000 : 5'b10000; e.dat = s_dat_i;
                eq.push_back(e);
            end
            if (tmo) begin
                e.n = n; e.v = (owner == 1) ? 5'b00010 : 5'b00100; e.dat = 32'h0;
                eq.push_back(e);
                if (!rst) begin
                    e.n = n + 1; e.v = 5'b00001;
                    eq.push_back(e);
                end
            end
            since = (stb && !ack && !tmo) ? ((since < 0) ? n : since) : -1;
            if (tmo || !cx) owner = -1;
        end
        if (rst) begin
            owner = -1; last = 1; since = -1;
        end
        n++;
    endtask

    always @(negedge wb_clk_i) begin
        cyc_t r;
        ev_t  e;
        logic [4:0] v;
        if (cq.size() > 0) begin
            r = cq.pop_front();
            chk("grant", 32'(grant_o), 32'(r.g));
            chk("s_cyc", 32'(s_cyc_o), 32'(r.c));
            chk("s_stb", 32'(s_stb_o), 32'(r.s));
            chk("s_adr", s_adr_o, r.adr);
            if (r.g == 2'b00) begin
                chk("idle_we_sel", 32'({s_we_o, s_sel_o}), 32'h0);
                chk("idle_dat", s_dat_o, 32'h0);
            end
            while (eq.size() > 0 && eq[0].n < r.n) begin
                e = eq.pop_front();
                chk("missing_event", 32'h0, 32'(e.v));
            end
            v = {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, irq_o};
            if (eq.size() > 0 && eq[0].n == r.n) begin
                e = eq.pop_front();
                chk("event", 32'(v), 32'(e.v));
                if (e.v[4] | e.v[3]) begin
                    chk("m0_dat", m0_dat_o, e.dat);
                    chk("m1_dat", m1_dat_o, e.dat);
                end
            end else begin
                chk("no_event", 32'(v), 32'h0);
            end
        end
    end

    initial begin
        logic [7:0] c0t, c1t, akt;
        logic [1:0] gx [8];
        logic rc0, rc1, rs0, rs1, rack, rrst;
        int ack_pct;
        repeat (2) @(posedge wb_clk_i);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // Single read by m0
        use_dir = 1'b1; dir_adr = 32'h3000_0004; dir_dat = 32'hDEAD_BEEF; dir_mdat = 32'h0;
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        @(negedge wb_clk_i);
        chk("t1_grant", 32'(grant_o), 32'h1);
        chk("t1_ack0", 32'(m0_ack_o), 32'h1);
        chk("t1_dat", m0_dat_o, 32'hDEAD_BEEF);
        chk("t1_ack1", 32'(m1_ack_o), 32'h0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Round-robin with single-beat cycles from both masters
        c0t = 8'b1111_1011; c1t = 8'b1101_1111; akt = 8'b0001_0010;
        gx = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
        step(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            step(c0t[k], c0t[k], c1t[k], c1t[k], akt[k], 0);
            @(negedge wb_clk_i);
            chk("t2_grant", 32'(grant_o), 32'(gx[k]));
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Burst lock: three m0 writes while m1 keeps requesting
        step(0, 0, 0, 0, 0, 1);
        dir_adr = 32'h3000_0000; dir_mdat = 32'h11;
        step(1, 1, 1, 1, 0, 0);
        for (int j = 1; j <= 3; j++) begin
            dir_adr = 32'h3000_0000 + 32'(4 * (j - 1));
            dir_mdat = 32'(32'h11 * j);
            step(1, 1, 1, 1, 1, 0);
            @(negedge wb_clk_i);
            chk("t3_adr", s_adr_o, 32'h3000_0000 + 32'(4 * (j - 1)));
            chk("t3_dat", s_dat_o, 32'(32'h11 * j));
        end
        step(0, 0, 1, 1, 0, 0);
        @(negedge wb_clk_i); chk("t3_release", 32'(grant_o), 32'h1);
        step(0, 0, 1, 1, 0, 0);
        @(negedge wb_clk_i); chk("t3_idle", 32'(grant_o), 32'h0);
        step(0, 0, 1, 1, 1, 0);
        @(negedge wb_clk_i); chk("t3_m1", 32'(grant_o), 32'h2);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Timeout on m1's stalled write
        step(0, 0, 1, 1, 0, 0);
        for (int i = 0; i <= T; i++) begin
            step(0, 0, 1, 1, 0, 0);
            @(negedge wb_clk_i);
            chk("t4_err", 32'(m1_err_o), 32'(i == T));
        end
        chk("t4_scyc", 32'(s_cyc_o), 32'h0);
        step(0, 0, 0, 0, 0, 0);
        @(negedge wb_clk_i);
        chk("t4_irq", 32'(irq_o), 32'h1);
        chk("t4_grant", 32'(grant_o), 32'h0);
        step(0, 0, 0, 0, 0, 0);
        @(negedge wb_clk_i); chk("t4_irq_end", 32'(irq_o), 32'h0);

        // Ack exactly at the limit, then a fresh stall must take the full count again
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i <= T + 5; i++) begin
            step(1, 1, 0, 0, i == T, 0);
            @(negedge wb_clk_i);
            chk("t5_ack", 32'(m0_ack_o), 32'(i == T));
            chk("t5_err", 32'(m0_err_o), 32'(i == T + 5));
            chk("t5_irq", 32'(irq_o), 32'h0);
        end
        step(0, 0, 0, 0, 0, 0);
        @(negedge wb_clk_i); chk("t5_irq_late", 32'(irq_o), 32'h1);
        step(0, 0, 0, 0, 0, 0);

        // Reset during m0's second beat
        step(0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 1, 1, 0, 0);
        @(negedge wb_clk_i);
        chk("t6_ctl", 32'({grant_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o,
                           m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, irq_o}), 32'h0);
        chk("t6_adr", s_adr_o, 32'h0);
        chk("t6_dat", s_dat_o, 32'h0);
        step(1, 1, 1, 1, 0, 0);
        @(negedge wb_clk_i); chk("t6_first", 32'(grant_o), 32'h1);
        step(0, 0, 0, 0, 0, 0);

        // Randomized traffic with varying slave responsiveness and occasional reset
        use_dir = 1'b0;
        rc0 = 1'b0; rc1 = 1'b0; ack_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) ack_pct = ((i / 250) % 3 == 0) ? 10 : ((i / 250) % 3 == 1) ? 50 : 90;
            if ($urandom_range(99) < 15) rc0 = ~rc0;
            if ($urandom_range(99) < 15) rc1 = ~rc1;
            rs0 = rc0 & ($urandom_range(3) != 0);
            rs1 = rc1 & ($urandom_range(3) != 0);
            rack = $urandom_range(99) < ack_pct;
            rrst = $urandom_range(399) == 0;
            step(rc0, rs0, rc1, rs1, rack, rrst);
        end
        repeat (3) step(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10 && cq.size() > 0; k++) @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("drain", 32'(cq.size() + eq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
